// File: rtl/fix_tx_scheduler_if.sv
// Signal bundle between the FIX transmit scheduler and the session/encoder logic.
// The slave side is the scheduler; the master side drives requests and completions.
interface fix_tx_scheduler_if #(
   parameter int unsigned SEQ_W = 32
);
   logic             start_session;
   logic             stop_session;
   logic             logon_ack;
   logic             logout_ack;
   logic             order_req;
   logic             resend_req;
   logic             reject_req;
   logic             enc_done;
   logic [5:0]       enc_en;
   logic [5:0]       req_ack;
   logic             busy;
   logic [1:0]       session_state;
   logic [SEQ_W-1:0] tx_seq_num;
   logic             timeout_err;

   modport master (
      output start_session, stop_session, logon_ack, logout_ack,
             order_req, resend_req, reject_req, enc_done,
      input  enc_en, req_ack, busy, session_state, tx_seq_num, timeout_err
   );

   modport slave (
      input  start_session, stop_session, logon_ack, logout_ack,
             order_req, resend_req, reject_req, enc_done,
      output enc_en, req_ack, busy, session_state, tx_seq_num, timeout_err
   );
endinterface

// File: rtl/fix_tx_scheduler.sv
// FIX transmit scheduler: session FSM, heartbeat timer, one-at-a-time encoder
// arbitration with completion timeout, and outgoing MsgSeqNum tracking.
module fix_tx_scheduler #(
   parameter int unsigned HB_INTERVAL  = 1000000,
   parameter int unsigned DONE_TIMEOUT = 64,
   parameter int unsigned SEQ_W        = 32
) (
   input logic               clk,
   input logic               rst,
   fix_tx_scheduler_if.slave bus
);

   localparam int unsigned HB_W = (HB_INTERVAL  > 1) ? $clog2(HB_INTERVAL)  : 1;
   localparam int unsigned WT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

   localparam int unsigned B_ORDER  = 0;
   localparam int unsigned B_LOGON  = 1;
   localparam int unsigned B_HB     = 2;
   localparam int unsigned B_RESEND = 3;
   localparam int unsigned B_REJECT = 4;
   localparam int unsigned B_LOGOUT = 5;

   typedef enum logic [1:0] {
      S_DISC        = 2'd0,
      S_LOGON_SENT  = 2'd1,
      S_ACTIVE      = 2'd2,
      S_LOGOUT_SENT = 2'd3
   } sess_t;

   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_GRANT = 2'd1,
      T_WAIT  = 2'd2
   } tx_t;

   sess_t            r_sess;
   sess_t            w_sess_next;
   tx_t              r_tx_state;
   tx_t              w_tx_next;

   logic [5:0]       r_sel;
   logic [5:0]       r_req_ack;
   logic             r_tmo;
   logic [SEQ_W-1:0] r_seq;
   logic [WT_W-1:0]  r_wait_cnt;
   logic [HB_W-1:0]  r_hb_cnt;
   logic             r_hb_pend;
   logic             r_start_pend;
   logic             r_stop_pend;

   logic [5:0]       w_cand;
   logic [5:0]       w_enc_en;
   logic             w_busy;
   logic             w_latch;
   logic             w_done;
   logic             w_tmo;
   logic             w_seq_rst;
   logic             w_hb_term;

   assign w_hb_term = (r_hb_cnt == HB_W'(HB_INTERVAL - 1));
   assign w_seq_rst = (r_sess == S_LOGOUT_SENT) && bus.logout_ack;

   // Logout outranks everything in ACTIVE; an in-flight grant is protected
   // because candidates are only consumed from T_IDLE.
   always_comb begin
      w_cand = '0;
      case (r_sess)
         S_DISC: w_cand[B_LOGON] = r_start_pend;
         S_ACTIVE: begin
            if (r_stop_pend)          w_cand[B_LOGOUT] = 1'b1;
            else if (bus.reject_req)  w_cand[B_REJECT] = 1'b1;
            else if (bus.resend_req)  w_cand[B_RESEND] = 1'b1;
            else if (r_hb_pend)       w_cand[B_HB]     = 1'b1;
            else if (bus.order_req)   w_cand[B_ORDER]  = 1'b1;
         end
         default: w_cand = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tx_state <= T_IDLE;
      else     r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      w_enc_en  = '0;
      w_busy    = 1'b0;
      w_latch   = 1'b0;
      w_done    = 1'b0;
      w_tmo     = 1'b0;
      case (r_tx_state)
         T_IDLE: begin
            if (|w_cand) begin
               w_latch   = 1'b1;
               w_tx_next = T_GRANT;
            end
         end
         T_GRANT: begin
            w_enc_en  = r_sel;
            w_tx_next = T_WAIT;
         end
         T_WAIT: begin
            w_busy = 1'b1;
            // A completion on the terminal-count cycle still counts as done.
            if (bus.enc_done) begin
               w_done    = 1'b1;
               w_tx_next = T_IDLE;
            end else if (r_wait_cnt == WT_W'(DONE_TIMEOUT - 1)) begin
               w_tmo     = 1'b1;
               w_tx_next = T_IDLE;
            end
         end
         default: w_tx_next = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sess <= S_DISC;
      else     r_sess <= w_sess_next;
   end

   always_comb begin
      w_sess_next = r_sess;
      case (r_sess)
         S_DISC:        if (w_done && r_sel[B_LOGON])  w_sess_next = S_LOGON_SENT;
         S_LOGON_SENT:  if (bus.logon_ack)             w_sess_next = S_ACTIVE;
         S_ACTIVE:      if (w_done && r_sel[B_LOGOUT]) w_sess_next = S_LOGOUT_SENT;
         S_LOGOUT_SENT: if (bus.logout_ack)            w_sess_next = S_DISC;
         default:       w_sess_next = S_DISC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel        <= '0;
         r_req_ack    <= '0;
         r_tmo        <= 1'b0;
         r_seq        <= SEQ_W'(1);
         r_wait_cnt   <= '0;
         r_hb_cnt     <= '0;
         r_hb_pend    <= 1'b0;
         r_start_pend <= 1'b0;
         r_stop_pend  <= 1'b0;
      end else begin
         if (w_latch) r_sel <= w_cand;
         r_req_ack  <= w_done ? r_sel : '0;
         r_tmo      <= w_tmo;
         r_wait_cnt <= (r_tx_state == T_WAIT) ? r_wait_cnt + WT_W'(1) : '0;

         if (w_seq_rst)   r_seq <= SEQ_W'(1);
         else if (w_done) r_seq <= r_seq + SEQ_W'(1);

         if (w_done && r_sel[B_LOGON])                r_start_pend <= 1'b0;
         else if (r_sess == S_DISC && bus.start_session) r_start_pend <= 1'b1;

         if (w_done && r_sel[B_LOGOUT])                 r_stop_pend <= 1'b0;
         else if (r_sess == S_ACTIVE && bus.stop_session) r_stop_pend <= 1'b1;

         // Counter parks at its terminal value until an encode restarts it.
         if (r_sess != S_ACTIVE || bus.enc_done) r_hb_cnt <= '0;
         else if (!w_hb_term)                    r_hb_cnt <= r_hb_cnt + HB_W'(1);

         if (r_sess != S_ACTIVE)                      r_hb_pend <= 1'b0;
         else if (w_done && r_sel[B_HB])              r_hb_pend <= 1'b0;
         else if (w_hb_term)                          r_hb_pend <= 1'b1;
      end
   end

   assign bus.enc_en        = w_enc_en;
   assign bus.req_ack       = r_req_ack;
   assign bus.busy          = w_busy;
   assign bus.session_state = r_sess;
   assign bus.tx_seq_num    = r_seq;
   assign bus.timeout_err   = r_tmo;

endmodule

// File: tb/tb_fix_tx_scheduler.sv
// Directed bench for fix_tx_scheduler: a per-cycle vector table for logon and a
// first order, then hand sequences for heartbeat, priority, timeout, logout, reset.
module tb_fix_tx_scheduler;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fix_tx_scheduler_if #(.SEQ_W(32)) bus ();

   fix_tx_scheduler #(
      .HB_INTERVAL (16),
      .DONE_TIMEOUT(8),
      .SEQ_W       (32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // in bits: 7 start, 6 stop, 5 logon_ack, 4 logout_ack, 3 order, 2 resend, 1 reject, 0 enc_done
   typedef struct packed {
      logic [7:0]  in;
      logic [5:0]  en;
      logic [5:0]  ack;
      logic        busy;
      logic [1:0]  state;
      logic [31:0] seq;
      logic        tmo;
   } vec_t;

   vec_t        vecs [18];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] m_seq;

   function automatic vec_t mk(input logic [7:0] in, input logic [5:0] en, input logic [5:0] ack,
                               input logic busy, input logic [1:0] state, input logic [31:0] seq,
                               input logic tmo);
      vec_t v;
      v.in = in; v.en = en; v.ack = ack; v.busy = busy;
      v.state = state; v.seq = seq; v.tmo = tmo;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input logic [7:0] in);
      {bus.start_session, bus.stop_session, bus.logon_ack, bus.logout_ack,
       bus.order_req, bus.resend_req, bus.reject_req, bus.enc_done} = in;
   endtask

   // Wait (bounded) for a grant, check it, complete it after dly cycles and check the ack.
   task automatic txn(input string nm, input logic [5:0] exp, input int unsigned dly);
      int unsigned n = 0;
      while (bus.enc_en == 6'b0 && n < 40) begin
         cyc();
         n++;
      end
      check({nm, " grant"}, 32'(bus.enc_en), 32'(exp));
      repeat (dly) cyc();
      if (exp[0]) bus.order_req  = 1'b0;
      if (exp[3]) bus.resend_req = 1'b0;
      if (exp[4]) bus.reject_req = 1'b0;
      bus.enc_done = 1'b1;
      cyc();
      bus.enc_done = 1'b0;
      m_seq = m_seq + 1;
      check({nm, " ack"}, 32'(bus.req_ack), 32'(exp));
      check({nm, " seq"}, bus.tx_seq_num, m_seq);
   endtask

   task automatic check_outputs_zero(input string nm);
      check({nm, " enc_en"}, 32'(bus.enc_en), 32'd0);
      check({nm, " req_ack"}, 32'(bus.req_ack), 32'd0);
      check({nm, " busy"}, 32'(bus.busy), 32'd0);
      check({nm, " state"}, 32'(bus.session_state), 32'd0);
      check({nm, " seq"}, bus.tx_seq_num, 32'd1);
      check({nm, " tmo"}, 32'(bus.timeout_err), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n;
      logic [31:0] seq0;

      vecs[0]  = mk(8'h80, 6'h00, 6'h00, 1'b0, 2'd0, 32'd1, 1'b0);
      vecs[1]  = mk(8'h00, 6'h02, 6'h00, 1'b0, 2'd0, 32'd1, 1'b0);
      vecs[2]  = mk(8'h20, 6'h00, 6'h00, 1'b1, 2'd0, 32'd1, 1'b0);
      vecs[3]  = mk(8'h40, 6'h00, 6'h00, 1'b1, 2'd0, 32'd1, 1'b0);
      vecs[4]  = mk(8'h00, 6'h00, 6'h00, 1'b1, 2'd0, 32'd1, 1'b0);
      vecs[5]  = mk(8'h00, 6'h00, 6'h00, 1'b1, 2'd0, 32'd1, 1'b0);
      vecs[6]  = mk(8'h00, 6'h00, 6'h00, 1'b1, 2'd0, 32'd1, 1'b0);
      vecs[7]  = mk(8'h01, 6'h00, 6'h02, 1'b0, 2'd1, 32'd2, 1'b0);
      vecs[8]  = mk(8'h40, 6'h00, 6'h00, 1'b0, 2'd1, 32'd2, 1'b0);
      vecs[9]  = mk(8'h20, 6'h00, 6'h00, 1'b0, 2'd2, 32'd2, 1'b0);
      vecs[10] = mk(8'h08, 6'h01, 6'h00, 1'b0, 2'd2, 32'd2, 1'b0);
      vecs[11] = mk(8'h08, 6'h00, 6'h00, 1'b1, 2'd2, 32'd2, 1'b0);
      vecs[12] = mk(8'h01, 6'h00, 6'h01, 1'b0, 2'd2, 32'd3, 1'b0);
      vecs[13] = mk(8'h00, 6'h00, 6'h00, 1'b0, 2'd2, 32'd3, 1'b0);
      vecs[14] = mk(8'h01, 6'h00, 6'h00, 1'b0, 2'd2, 32'd3, 1'b0);
      vecs[15] = mk(8'h10, 6'h00, 6'h00, 1'b0, 2'd2, 32'd3, 1'b0);
      vecs[16] = mk(8'h80, 6'h00, 6'h00, 1'b0, 2'd2, 32'd3, 1'b0);
      vecs[17] = mk(8'h20, 6'h00, 6'h00, 1'b0, 2'd2, 32'd3, 1'b0);

      rst = 1'b1;
      drive(8'h00);
      repeat (2) cyc();
      check_outputs_zero("reset");
      rst = 1'b0;

      for (int unsigned i = 0; i < 18; i++) begin
         drive(vecs[i].in);
         cyc();
         check($sformatf("vec%0d enc_en", i), 32'(bus.enc_en), 32'(vecs[i].en));
         check($sformatf("vec%0d req_ack", i), 32'(bus.req_ack), 32'(vecs[i].ack));
         check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d state", i), 32'(bus.session_state), 32'(vecs[i].state));
         check($sformatf("vec%0d seq", i), bus.tx_seq_num, vecs[i].seq);
         check($sformatf("vec%0d tmo", i), 32'(bus.timeout_err), 32'(vecs[i].tmo));
      end
      drive(8'h00);
      m_seq = 32'd3;

      // Heartbeat: an order completion restarts the interval, then two heartbeats.
      bus.order_req = 1'b1;
      txn("hb_pre_order", 6'b000001, 1);
      for (int unsigned k = 0; k < 2; k++) begin
         n = 1;
         while (bus.enc_en == 6'b0 && n < 40) begin
            cyc();
            n++;
         end
         check($sformatf("hb%0d interval_ok", k), 32'((n == 17) || (n == 18)), 32'd1);
         txn($sformatf("hb%0d", k), 6'b000100, 1);
      end

      // Fixed priority among level requests.
      seq0 = m_seq;
      bus.order_req  = 1'b1;
      bus.resend_req = 1'b1;
      bus.reject_req = 1'b1;
      txn("prio_reject", 6'b010000, 2);
      txn("prio_resend", 6'b001000, 2);
      txn("prio_order",  6'b000001, 2);
      check("prio seq+3", bus.tx_seq_num, seq0 + 32'd3);

      // Withheld completion: timeout, no increment, then regrant.
      bus.order_req = 1'b1;
      n = 0;
      while (bus.enc_en == 6'b0 && n < 40) begin
         cyc();
         n++;
      end
      check("tmo grant", 32'(bus.enc_en), 32'h01);
      n = 0;
      while (!bus.timeout_err && n < 40) begin
         cyc();
         n++;
      end
      check("tmo latency", n, 32'd9);
      check("tmo req_ack", 32'(bus.req_ack), 32'd0);
      check("tmo seq", bus.tx_seq_num, m_seq);
      txn("tmo_regrant", 6'b000001, 1);

      // Completion on the terminal-count cycle wins over the timeout.
      bus.order_req = 1'b1;
      txn("race", 6'b000001, 8);
      check("race tmo", 32'(bus.timeout_err), 32'd0);
      cyc();
      check("race tmo_late", 32'(bus.timeout_err), 32'd0);

      // Stop during an in-flight order: order completes first, then logout.
      bus.order_req = 1'b1;
      n = 0;
      while (bus.enc_en == 6'b0 && n < 40) begin
         cyc();
         n++;
      end
      check("stop order grant", 32'(bus.enc_en), 32'h01);
      cyc();
      bus.stop_session = 1'b1;
      cyc();
      bus.stop_session = 1'b0;
      cyc();
      bus.order_req = 1'b0;
      bus.enc_done  = 1'b1;
      cyc();
      bus.enc_done  = 1'b0;
      m_seq = m_seq + 1;
      check("stop order ack", 32'(bus.req_ack), 32'h01);
      check("stop order seq", bus.tx_seq_num, m_seq);
      check("stop still active", 32'(bus.session_state), 32'd2);
      txn("logout", 6'b100000, 1);
      check("logout state", 32'(bus.session_state), 32'd3);

      bus.order_req = 1'b1;
      bus.logon_ack = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         cyc();
         bus.logon_ack = 1'b0;
         check($sformatf("logout_sent no_grant%0d", k), 32'(bus.enc_en), 32'd0);
         check($sformatf("logout_sent state%0d", k), 32'(bus.session_state), 32'd3);
      end
      bus.order_req  = 1'b0;
      bus.logout_ack = 1'b1;
      cyc();
      bus.logout_ack = 1'b0;
      m_seq = 32'd1;
      check("disc state", 32'(bus.session_state), 32'd0);
      check("disc seq", bus.tx_seq_num, m_seq);

      // Start and stop together while disconnected: logon is granted.
      bus.start_session = 1'b1;
      bus.stop_session  = 1'b1;
      cyc();
      bus.start_session = 1'b0;
      bus.stop_session  = 1'b0;
      n = 0;
      while (bus.enc_en == 6'b0 && n < 40) begin
         cyc();
         n++;
      end
      check("restart logon grant", 32'(bus.enc_en), 32'h02);
      cyc();
      check("restart busy", 32'(bus.busy), 32'd1);

      // Asynchronous reset mid-wait, then a stray completion.
      rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      cyc();
      bus.enc_done = 1'b1;
      cyc();
      bus.enc_done = 1'b0;
      check_outputs_zero("post_rst_done");
      for (int unsigned k = 0; k < 3; k++) begin
         cyc();
         check($sformatf("post_rst idle%0d", k), 32'(bus.enc_en), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fix_tx_scheduler.md
Name: fix_tx_scheduler

Overview:
- Sequences the FIX transmit encoders (order D/F/G/H/1, logon A, heartbeat 0, resend 2, reject 3, logout 5) into the shared header encoder.
- Owns the session state machine and the heartbeat interval timer.
- Arbitrates pending requests so exactly one encoder is enabled per transmission, then waits for the header encoder's encoded pulse before granting again.
- Tracks the outgoing MsgSeqNum.

Parameters:
- HB_INTERVAL, 1000000: idle cycles in ACTIVE before a heartbeat is requested.
- DONE_TIMEOUT, 64: max cycles from grant to enc_done before the grant is abandoned.
- SEQ_W, 32: width of the sequence counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- start_session, input, 1: pulse; begin logon from DISCONNECTED.
- stop_session, input, 1: pulse; begin logout from ACTIVE.
- logon_ack, input, 1: pulse; counterparty logon A received.
- logout_ack, input, 1: pulse; counterparty logout 5 received.
- order_req, input, 1: level; order encoder has a message pending.
- resend_req, input, 1: level; resend (2) required.
- reject_req, input, 1: level; reject (3) required.
- enc_done, input, 1: pulse from header encoder (encoded).
- enc_en, output, 6: one-hot encoder enable. Bit 0 order, 1 logon, 2 heartbeat, 3 resend, 4 reject, 5 logout.
- req_ack, output, 6: one-hot pulse, same bit map; the granted message completed.
- busy, output, 1: a grant is outstanding.
- session_state, output, 2: 0 DISCONNECTED, 1 LOGON_SENT, 2 ACTIVE, 3 LOGOUT_SENT.
- tx_seq_num, output, SEQ_W: sequence number of the next message.
- timeout_err, output, 1: pulse; grant abandoned.

Behaviour:
- Reset values: all outputs 0; session DISCONNECTED; tx FSM T_IDLE; tx_seq_num = 1; heartbeat counter 0.
- Reset asserted mid-grant aborts immediately. No ack is issued.

Tx FSM:
- T_IDLE: if a candidate exists, latch the selected bit, go to T_GRANT.
- T_GRANT: enc_en = selected bit for exactly one cycle, then T_WAIT with the wait counter cleared.
- T_WAIT: busy = 1.
  - On enc_done: req_ack bit pulses next cycle, tx_seq_num increments (wraps at 2^SEQ_W-1 to 0), go to T_IDLE.
  - If the wait counter reaches DONE_TIMEOUT-1 without enc_done: timeout_err pulses, no ack, no increment, go to T_IDLE. A level request is then re-arbitrated.
- enc_done outside T_WAIT is ignored.
- Minimum spacing between grants: 3 cycles.

Candidates by session state:
- DISCONNECTED: logon, when start_session is seen (latched pending flag).
- LOGON_SENT: none.
- ACTIVE: fixed priority reject > resend > heartbeat > order. Logout (pending flag from stop_session) outranks all except an in-flight grant.
- LOGOUT_SENT: none.

Session FSM:
- DISCONNECTED -> LOGON_SENT on logon req_ack.
- LOGON_SENT -> ACTIVE on logon_ack.
- ACTIVE -> LOGOUT_SENT on logout req_ack.
- LOGOUT_SENT -> DISCONNECTED on logout_ack; tx_seq_num resets to 1.
- logon_ack / logout_ack in any other state is ignored.
- start_session outside DISCONNECTED is ignored.
- stop_session outside ACTIVE is ignored.
- Pending flags clear on their req_ack.

Heartbeat:
- Counter runs only in ACTIVE. Clears on any enc_done and on entry to ACTIVE.
- At HB_INTERVAL-1 it sets hb_pending (saturates) and holds until the heartbeat is acked.
- hb_pending clears when leaving ACTIVE.

Simultaneous events:
- start_session and stop_session in the same cycle in DISCONNECTED: start wins.
- enc_done on the same cycle as the timeout terminal count: enc_done wins.

Test Plan:
- Reset, pulse start_session, enc_done 5 cycles after grant -> enc_en = 6'b000010 one cycle, req_ack[1] pulse, state 1, tx_seq_num = 2; logon_ack -> state 2.
- ACTIVE with order_req, resend_req and reject_req all high -> grants in order bit 4, 3, 0, each after its enc_done; tx_seq_num advances by 3.
- HB_INTERVAL = 16, ACTIVE, no traffic -> enc_en = 6'b000100 on the 17th or 18th idle cycle. Counter restarts after enc_done.
- Grant order, withhold enc_done (DONE_TIMEOUT = 8) -> timeout_err after 8 wait cycles, tx_seq_num unchanged, order regranted.
- stop_session during in-flight order -> order completes and is acked, then logout grant; logout_ack -> state 0, tx_seq_num = 1.
- Assert rst during T_WAIT -> all outputs 0 immediately; later enc_done is ignored.
